itch_feed_arbiter: RTL and testbench

ITCH_FEED_ARBITER -- requirements
Module: itch_feed_arbiter

---
 rtl/itch_feed_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_itch_feed_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/itch_feed_arbiter.sv
// rtl/itch_feed_arbiter.sv - two-feed packet arbiter with idle-timeout abort and statistics
module itch_feed_arbiter #(
  parameter int DATA_W  = 64,
  parameter int LEN_W   = 3,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_sof,
  input  logic              s0_eof,
  input  logic [LEN_W-1:0]  s0_len,
  input  logic              s0_vld,
  output logic              s0_rdy,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_sof,
  input  logic              s1_eof,
  input  logic [LEN_W-1:0]  s1_len,
  input  logic              s1_vld,
  output logic              s1_rdy,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eof,
  output logic [LEN_W-1:0]  m_len,
  output logic              m_vld,
  output logic              m_err,
  input  logic              m_rdy,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  abort_cnt
);

  localparam int TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, ABORT = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0]   pkt_cnt1_q, pkt_cnt1_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   abort_cnt_q, abort_cnt_d;

  // Owner-selected view of the feed inputs
  logic [DATA_W-1:0]  own_data;
  logic               own_sof, own_eof, own_vld;
  logic [LEN_W-1:0]   own_len;
  logic               own_accept;
  logic               req0, req1, drop0, drop1;
  logic [TMO_W-1:0]   tmo_inc;

  assign own_data   = owner_q ? s1_data : s0_data;
  assign own_sof    = owner_q ? s1_sof  : s0_sof;
  assign own_eof    = owner_q ? s1_eof  : s0_eof;
  assign own_len    = owner_q ? s1_len  : s0_len;
  assign own_vld    = owner_q ? s1_vld  : s0_vld;
  assign own_accept = own_vld & m_rdy;
  assign req0       = s0_vld & s0_sof;
  assign req1       = s1_vld & s1_sof;
  assign drop0      = s0_vld & ~s0_sof;
  assign drop1      = s1_vld & ~s1_sof;
  assign tmo_inc    = tmo_q + TMO_W'(1);

  assign pkt_cnt0   = pkt_cnt0_q;
  assign pkt_cnt1   = pkt_cnt1_q;
  assign drop_cnt   = drop_cnt_q;
  assign abort_cnt  = abort_cnt_q;

  // State and statistics registers; last_owner resets to 1 so feed 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      tmo_q        <= '0;
      pkt_cnt0_q   <= '0;
      pkt_cnt1_q   <= '0;
      drop_cnt_q   <= '0;
      abort_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      tmo_q        <= tmo_d;
      pkt_cnt0_q   <= pkt_cnt0_d;
      pkt_cnt1_q   <= pkt_cnt1_d;
      drop_cnt_q   <= drop_cnt_d;
      abort_cnt_q  <= abort_cnt_d;
    end
  end

  // Next-state: arbitration in IDLE, packet tracking and idle timeout in OWN
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    tmo_d        = tmo_q;
    pkt_cnt0_d   = pkt_cnt0_q;
    pkt_cnt1_d   = pkt_cnt1_q;
    drop_cnt_d   = drop_cnt_q;
    abort_cnt_d  = abort_cnt_q;
    case (state_q)
      IDLE: begin
        drop_cnt_d = drop_cnt_q + CNT_W'(drop0) + CNT_W'(drop1);
        if (req0 | req1) begin
          state_d      = OWN;
          owner_d      = (req0 & req1) ? ~last_owner_q : req1;
          last_owner_d = owner_d;
          tmo_d        = '0;
        end
      end
      OWN: begin
        if (own_accept) begin
          tmo_d = '0;
          if (own_eof) begin
            state_d = IDLE;
            if (owner_q) pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
            else         pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
          end
        end else if (!own_vld) begin
          // A stalled valid beat holds the counter; only a silent owner advances it
          if (tmo_inc == TMO_W'(TIMEOUT)) begin
            state_d = ABORT;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_inc;
          end
        end
      end
      ABORT: begin
        if (m_rdy) begin
          state_d     = IDLE;
          abort_cnt_d = abort_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: discard orphans in IDLE, forward owner in OWN, synthetic error beat in ABORT
  always_comb begin
    m_data = '0;
    m_sof  = 1'b0;
    m_eof  = 1'b0;
    m_len  = '0;
    m_vld  = 1'b0;
    m_err  = 1'b0;
    s0_rdy = 1'b0;
    s1_rdy = 1'b0;
    grant  = 2'b00;
    case (state_q)
      IDLE: begin
        s0_rdy = ~s0_sof & ~rst;
        s1_rdy = ~s1_sof & ~rst;
      end
      OWN: begin
        m_data = own_data;
        m_sof  = own_sof;
        m_eof  = own_eof;
        m_len  = own_len;
        m_vld  = own_vld;
        s0_rdy = ~owner_q & m_rdy;
        s1_rdy = owner_q & m_rdy;
        grant  = owner_q ? 2'b10 : 2'b01;
      end
      ABORT: begin
        m_vld = 1'b1;
        m_eof = 1'b1;
        m_err = 1'b1;
        grant = owner_q ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_itch_feed_arbiter.sv
// tb/tb_itch_feed_arbiter.sv - directed self-checking bench for itch_feed_arbiter
module tb_itch_feed_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s0_data, s1_data, m_data;
  logic        s0_sof, s0_eof, s0_vld, s0_rdy;
  logic        s1_sof, s1_eof, s1_vld, s1_rdy;
  logic [2:0]  s0_len, s1_len, m_len;
  logic        m_sof, m_eof, m_vld, m_err, m_rdy;
  logic [1:0]  grant;
  logic [15:0] pkt_cnt0, pkt_cnt1, drop_cnt, abort_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  itch_feed_arbiter #(.DATA_W(64), .LEN_W(3), .TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .s0_data(s0_data), .s0_sof(s0_sof), .s0_eof(s0_eof), .s0_len(s0_len),
    .s0_vld(s0_vld), .s0_rdy(s0_rdy),
    .s1_data(s1_data), .s1_sof(s1_sof), .s1_eof(s1_eof), .s1_len(s1_len),
    .s1_vld(s1_vld), .s1_rdy(s1_rdy),
    .m_data(m_data), .m_sof(m_sof), .m_eof(m_eof), .m_len(m_len),
    .m_vld(m_vld), .m_err(m_err), .m_rdy(m_rdy), .grant(grant),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .drop_cnt(drop_cnt), .abort_cnt(abort_cnt)
  );

  task automatic idle_inputs();
    s0_data = '0; s0_sof = 0; s0_eof = 0; s0_len = 0; s0_vld = 0;
    s1_data = '0; s1_sof = 0; s1_eof = 0; s1_len = 0; s1_vld = 0;
    m_rdy = 1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    s0_vld = 1; s1_vld = 1;
    #3;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
    checks++; if ({m_vld, m_err, m_sof, m_eof} !== 4'b0) begin errors++; $display("FAIL reset_mflags got %b exp 0000", {m_vld, m_err, m_sof, m_eof}); end
    checks++; if ({s0_rdy, s1_rdy} !== 2'b00) begin errors++; $display("FAIL reset_rdy got %b exp 00", {s0_rdy, s1_rdy}); end
    checks++; if ({m_data, m_len} !== '0) begin errors++; $display("FAIL reset_mdata got %h/%h exp 0", m_data, m_len); end
    checks++; if ({pkt_cnt0, pkt_cnt1, drop_cnt, abort_cnt} !== 64'd0) begin errors++; $display("FAIL reset_cnts got %h exp 0", {pkt_cnt0, pkt_cnt1, drop_cnt, abort_cnt}); end
    do_reset();
  endtask

  task automatic test_tie();
    do_reset();
    s0_vld = 1; s0_sof = 1; s0_data = 64'hA0;
    s1_vld = 1; s1_sof = 1; s1_data = 64'hB0;
    #1;
    checks++; if ({grant, m_vld, s0_rdy, s1_rdy} !== 5'b00000) begin errors++; $display("FAIL tie_req_cycle got %b exp 00000", {grant, m_vld, s0_rdy, s1_rdy}); end
    step();
    for (int b = 0; b < 3; b++) begin
      s0_data = 64'hA0 + 64'(b); s0_sof = (b == 0); s0_eof = (b == 2); s0_len = (b == 2) ? 3'd3 : 3'd0;
      #1;
      checks++;
      if ({grant, m_vld, m_sof, m_eof, s0_rdy, s1_rdy} !== {2'b01, 1'b1, b == 0, b == 2, 2'b10} || m_data !== 64'hA0 + 64'(b)) begin
        errors++; $display("FAIL tie_feed0_beat%0d got g=%b v=%b d=%h s0r=%b s1r=%b", b, grant, m_vld, m_data, s0_rdy, s1_rdy);
      end
      step();
    end
    s0_vld = 0;
    #1;
    checks++; if ({grant, m_vld, s1_rdy} !== 4'b0000 || pkt_cnt0 !== 16'd1) begin errors++; $display("FAIL tie_gap got g=%b v=%b r=%b p0=%0d exp 00/0/0/1", grant, m_vld, s1_rdy, pkt_cnt0); end
    step();
    for (int b = 0; b < 3; b++) begin
      s1_data = 64'hB0 + 64'(b); s1_sof = (b == 0); s1_eof = (b == 2);
      #1;
      checks++;
      if ({grant, m_vld, s1_rdy, s0_rdy} !== 5'b10110 || m_data !== 64'hB0 + 64'(b)) begin
        errors++; $display("FAIL tie_feed1_beat%0d got g=%b v=%b d=%h", b, grant, m_vld, m_data);
      end
      step();
    end
    s1_vld = 0;
    #1;
    checks++; if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd1) begin errors++; $display("FAIL tie_counts got %0d/%0d exp 1/1", pkt_cnt0, pkt_cnt1); end
  endtask

  task automatic test_backpressure();
    do_reset();
    s0_vld = 1; s0_sof = 1; s0_eof = 1; s0_len = 3'd5; s0_data = 64'hC5; m_rdy = 0;
    step();
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({m_vld, m_err, m_eof, s0_rdy} !== 4'b1010 || m_len !== 3'd5 || m_data !== 64'hC5) begin
        errors++; $display("FAIL bp_stall%0d got v=%b e=%b r=%b len=%0d", c, m_vld, m_err, s0_rdy, m_len);
      end
      step();
    end
    m_rdy = 1;
    #1;
    checks++; if ({m_vld, s0_rdy} !== 2'b11) begin errors++; $display("FAIL bp_release got %b exp 11", {m_vld, s0_rdy}); end
    step();
    s0_vld = 0;
    #1;
    checks++; if (pkt_cnt0 !== 16'd1 || abort_cnt !== 16'd0 || grant !== 2'b00) begin errors++; $display("FAIL bp_counts got p0=%0d ab=%0d g=%b exp 1/0/00", pkt_cnt0, abort_cnt, grant); end
  endtask

  task automatic test_timeout();
    do_reset();
    s0_vld = 1; s0_sof = 1; s0_data = 64'hD0;
    step();
    #1;
    checks++; if (s0_rdy !== 1'b1) begin errors++; $display("FAIL to_first_accept got %b exp 1", s0_rdy); end
    step();
    s0_vld = 0; s0_sof = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if ({m_vld, m_err} !== 2'b00) begin errors++; $display("FAIL to_idle%0d got %b exp 00", c, {m_vld, m_err}); end
      step();
    end
    #1;
    checks++;
    if ({m_vld, m_sof, m_eof, m_err, s0_rdy, s1_rdy} !== 6'b101100 || m_len !== 3'd0 || m_data !== 64'd0) begin
      errors++; $display("FAIL to_abort_beat got v=%b s=%b e=%b err=%b len=%0d d=%h", m_vld, m_sof, m_eof, m_err, m_len, m_data);
    end
    step();
    s0_vld = 1; s0_eof = 1; s0_data = 64'hD1;
    #1;
    checks++; if ({s0_rdy, m_vld} !== 2'b10 || abort_cnt !== 16'd1) begin errors++; $display("FAIL to_late_beat got r=%b v=%b ab=%0d exp 1/0/1", s0_rdy, m_vld, abort_cnt); end
    step();
    s0_vld = 0;
    #1;
    checks++; if (drop_cnt !== 16'd1 || pkt_cnt0 !== 16'd0) begin errors++; $display("FAIL to_counts got drop=%0d p0=%0d exp 1/0", drop_cnt, pkt_cnt0); end
  endtask

  task automatic test_orphans();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      s1_vld = 1; s1_sof = 0; s1_data = 64'hE0 + 64'(c);
      #1;
      checks++; if ({s1_rdy, m_vld} !== 2'b10) begin errors++; $display("FAIL orphan%0d got %b exp 10", c, {s1_rdy, m_vld}); end
      step();
    end
    s1_vld = 0;
    #1;
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL orphan_drops got %0d exp 2", drop_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    s0_vld = 1; s0_sof = 0;
    step();
    s0_sof = 1; s0_data = 64'hF0;
    step();
    step();
    s0_sof = 0; s0_data = 64'hF1;
    #1;
    checks++; if ({m_vld, grant} !== 3'b101 || drop_cnt !== 16'd1) begin errors++; $display("FAIL ar_midpkt got v=%b g=%b drop=%0d exp 1/01/1", m_vld, grant, drop_cnt); end
    #1 rst = 1;
    #1;
    checks++; if ({m_vld, grant, s0_rdy, m_err} !== 5'b00000 || drop_cnt !== 16'd0) begin errors++; $display("FAIL ar_async got v=%b g=%b r=%b err=%b drop=%0d exp 0/00/0/0/0", m_vld, grant, s0_rdy, m_err, drop_cnt); end
    s0_vld = 0;
    #1 rst = 0;
    step();
    s1_vld = 1; s1_sof = 1; s1_data = 64'h10;
    step();
    for (int b = 0; b < 2; b++) begin
      s1_sof = (b == 0); s1_eof = (b == 1); s1_data = 64'h10 + 64'(b);
      #1;
      checks++; if ({grant, m_vld, s1_rdy, m_err} !== 5'b10110 || m_data !== 64'h10 + 64'(b)) begin errors++; $display("FAIL ar_fresh_beat%0d got g=%b v=%b d=%h", b, grant, m_vld, m_data); end
      step();
    end
    s1_vld = 0;
    #1;
    checks++; if ({pkt_cnt0, pkt_cnt1, abort_cnt} !== {16'd0, 16'd1, 16'd0}) begin errors++; $display("FAIL ar_counts got %0d/%0d/%0d exp 0/1/0", pkt_cnt0, pkt_cnt1, abort_cnt); end
  endtask

  task automatic test_back_to_back();
    int p0, b0, p1, b1, seen;
    logic acc0, acc1;
    p0 = 0; b0 = 0; p1 = 0; b1 = 0; seen = 0;
    do_reset();
    for (int cyc = 0; cyc < 100 && !(p0 == 6 && p1 == 6); cyc++) begin
      s0_vld = (p0 < 6); s0_sof = (b0 == 0); s0_eof = (b0 == 1); s0_data = 64'(p0 * 16 + b0);
      s1_vld = (p1 < 6); s1_sof = (b1 == 0); s1_eof = (b1 == 1); s1_data = 64'(256 + p1 * 16 + b1);
      #1;
      if (m_vld && m_rdy && m_sof) begin
        checks++;
        if (grant !== ((seen % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_grant%0d got %b exp %b", seen, grant, (seen % 2) ? 2'b10 : 2'b01); end
        seen++;
      end
      acc0 = s0_vld & s0_rdy;
      acc1 = s1_vld & s1_rdy;
      step();
      if (acc0) begin if (b0 == 1) begin b0 = 0; p0++; end else b0++; end
      if (acc1) begin if (b1 == 1) begin b1 = 0; p1++; end else b1++; end
    end
    idle_inputs();
    #1;
    checks++; if (seen !== 12) begin errors++; $display("FAIL b2b_packets_seen got %0d exp 12", seen); end
    checks++; if (pkt_cnt0 !== 16'd6 || pkt_cnt1 !== 16'd6) begin errors++; $display("FAIL b2b_counts got %0d/%0d exp 6/6", pkt_cnt0, pkt_cnt1); end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_tie();
    test_backpressure();
    test_timeout();
    test_orphans();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
